// File: rtl/irq_pending_arb_pkg.sv
// Shared constants and helpers for the pending-request arbiter.
// The request count and index width come from here; onehot() turns an index back into a line mask.
package irq_pending_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_arb_if.sv
// Request/mask inputs and the valid/ready index output of irq_pending_arb.
// The slave side is the arbiter; the master side is the request source and the index consumer.
interface irq_pending_arb_if #(
  parameter int N = irq_pending_arb_pkg::N_REQ
) ();
  localparam int IW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  en_mask;
  logic          clr_all;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_ready;
  logic [N-1:0]  pending;

  modport master (
    output req, en_mask, clr_all, out_ready,
    input  out_valid, out_idx, pending
  );

  modport slave (
    input  req, en_mask, clr_all, out_ready,
    output out_valid, out_idx, pending
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational N-to-IW encoder: returns the highest set bit of vec; any flags a non-zero vector.
// idx is 0 when nothing is set.
module irq_prio_enc
  import irq_pending_arb_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Ascending scan: the last hit, which is the highest index, wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_pending_arb.sv
// Latches request events into a pending register and presents the highest enabled one as a registered index.
// Idle latency 2 edges with edge capture; the presented index is held, never retracted, while out_ready is low.
module irq_pending_arb
  import irq_pending_arb_pkg::*;
#(
  parameter int N    = N_REQ,
  parameter int EDGE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  irq_pending_arb_if.slave   bus
);

  localparam int IW = $clog2(N);

  logic [N-1:0]  req_dly_q, req_dly_d;
  logic [N-1:0]  pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q, out_idx_d;

  logic [N-1:0]  set_vec;
  logic [N-1:0]  clr_vec;
  logic [N-1:0]  cand;
  logic [IW-1:0] cand_idx;
  logic          cand_any;
  logic          accept;
  logic          load;

  assign accept = out_valid_q && bus.out_ready;
  assign load   = !out_valid_q || bus.out_ready;

  always_comb begin
    set_vec = (EDGE != 0) ? (bus.req & ~req_dly_q) : bus.req;

    clr_vec = '0;
    if (accept)      clr_vec = N'(onehot(IDX_W'(out_idx_q)));
    if (bus.clr_all) clr_vec = '1;

    // Set is OR-ed in after the clear so a fresh event on an acknowledged line survives.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    req_dly_d = bus.req;

    // Candidates come from the registered pending bits, not this cycle's new events.
    cand = pending_q & ~clr_vec & bus.en_mask;
  end

  irq_prio_enc #(
    .N  (N),
    .IW (IW)
  ) u_enc (
    .vec (cand),
    .idx (cand_idx),
    .any (cand_any)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (load) begin
      out_valid_d = cand_any;
      if (cand_any) out_idx_d = cand_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_dly_q   <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      req_dly_q   <= req_dly_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_irq_pending_arb.sv
// Bench for irq_pending_arb: directed scenarios plus a random run, checked each cycle
// against a per-line event model of the pending set and the presented index.
module tb_irq_pending_arb;
  import irq_pending_arb_pkg::*;

  logic clk;
  logic rst_n;

  irq_pending_arb_if #(.N(N_REQ)) bus ();

  irq_pending_arb #(.N(N_REQ), .EDGE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference state: one flag per line, plus the presented slot.
  bit m_pend [N_REQ];
  bit m_prev [N_REQ];
  bit m_vld;
  int m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < N_REQ; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_REQ; i++) begin
      m_pend[i] = 0;
      m_prev[i] = 0;
    end
    m_vld = 0;
    m_idx = 0;
  endtask

  // One clock edge of the rules: a line is acknowledged if accepted or globally cleared,
  // a new rising event always keeps it pending, and the presented slot refills from the
  // highest pending, enabled, not-acknowledged line whenever it is empty or being accepted.
  task automatic model_edge(input logic [7:0] r, input logic [7:0] m, input bit ca, input bit rdy);
    bit accepted;
    bit nxt [N_REQ];
    int pick;
    accepted = m_vld && rdy;
    for (int i = 0; i < N_REQ; i++) begin
      bit rose, acked;
      rose  = r[i] && !m_prev[i];
      acked = ca || (accepted && i == m_idx);
      if (rose)       nxt[i] = 1;
      else if (acked) nxt[i] = 0;
      else            nxt[i] = m_pend[i];
    end
    if (!m_vld || rdy) begin
      pick = -1;
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (pick < 0 && m_pend[i] && m[i] && !(ca || (accepted && i == m_idx))) pick = i;
      end
      m_vld = (pick >= 0);
      if (pick >= 0) m_idx = pick;
    end
    for (int i = 0; i < N_REQ; i++) begin
      m_pend[i] = nxt[i];
      m_prev[i] = r[i];
    end
  endtask

  // Called just after a rising edge: drive, advance model, wait one edge, compare.
  task automatic cyc(input logic [7:0] r, input logic [7:0] m, input bit ca, input bit rdy);
    bus.req       = r;
    bus.en_mask   = m;
    bus.clr_all   = ca;
    bus.out_ready = rdy;
    model_edge(r, m, ca, rdy);
    @(posedge clk);
    #1;
    check("pending",   32'(bus.pending),   32'(m_pend_vec()));
    check("out_valid", 32'(bus.out_valid), 32'(m_vld));
    check("out_idx",   32'(bus.out_idx),   32'(m_idx));
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.en_mask   = 8'hFF;
    bus.clr_all   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   32'(bus.out_valid), 32'd0);
    check("rst_idx",     32'(bus.out_idx),   32'd0);
    check("rst_pending", 32'(bus.pending),   32'd0);
    rst_n = 1'b1;

    // Single pulse, 2-edge latency then clear on acceptance
    cyc(8'h20, 8'hFF, 0, 1);
    check("basic_pend1", 32'(bus.pending), 32'h20);
    cyc(8'h00, 8'hFF, 0, 1);
    check("basic_vld2", 32'(bus.out_valid), 32'd1);
    check("basic_idx2", 32'(bus.out_idx),   32'd5);
    cyc(8'h00, 8'hFF, 0, 1);
    check("basic_pend3", 32'(bus.pending),   32'h00);
    check("basic_vld3",  32'(bus.out_valid), 32'd0);

    // Priority and back-to-back drain
    cyc(8'h8A, 8'hFF, 0, 1);
    cyc(8'h00, 8'hFF, 0, 1);
    check("b2b_idx7", 32'(bus.out_idx), 32'd7);
    cyc(8'h00, 8'hFF, 0, 1);
    check("b2b_idx3", 32'(bus.out_idx), 32'd3);
    cyc(8'h00, 8'hFF, 0, 1);
    check("b2b_idx1", 32'(bus.out_idx), 32'd1);
    cyc(8'h00, 8'hFF, 0, 1);
    check("b2b_empty", 32'(bus.out_valid), 32'd0);
    check("b2b_pend",  32'(bus.pending),   32'd0);

    // Hold under backpressure despite higher request and mask drop
    cyc(8'h04, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    cyc(8'h80, 8'hFB, 0, 0);
    cyc(8'h00, 8'hFB, 0, 0);
    check("hold_vld", 32'(bus.out_valid), 32'd1);
    check("hold_idx", 32'(bus.out_idx),   32'd2);
    cyc(8'h00, 8'hFB, 0, 1);
    check("hold_next_idx", 32'(bus.out_idx), 32'd7);
    cyc(8'h00, 8'hFF, 0, 1);

    // Masked lines latch but stay hidden until enabled
    cyc(8'hF0, 8'h0F, 0, 1);
    cyc(8'h00, 8'h0F, 0, 1);
    check("mask_pend", 32'(bus.pending),   32'hF0);
    check("mask_vld",  32'(bus.out_valid), 32'd0);
    cyc(8'h00, 8'hFF, 0, 1);
    check("unmask_idx", 32'(bus.out_idx), 32'd7);
    repeat (4) cyc(8'h00, 8'hFF, 0, 1);
    check("mask_drained", 32'(bus.pending), 32'd0);

    // New rising event on the line being accepted survives
    cyc(8'h10, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    cyc(8'h10, 8'hFF, 0, 1);
    check("setwin_pend", 32'(bus.pending), 32'h10);
    cyc(8'h00, 8'hFF, 0, 0);
    check("setwin_idx", 32'(bus.out_idx), 32'd4);
    cyc(8'h00, 8'hFF, 0, 1);

    // clr_all under backpressure keeps the presented index
    cyc(8'h06, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 1, 0);
    check("clr_hold_idx", 32'(bus.out_idx), 32'd2);
    cyc(8'h00, 8'hFF, 0, 1);
    check("clr_done_vld", 32'(bus.out_valid), 32'd0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [7:0] r, m;
      r = 8'($urandom) & 8'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      cyc(r, m, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset between edges
    cyc(8'h00, 8'hFF, 1, 1);
    cyc(8'h33, 8'hFF, 0, 0);
    cyc(8'h00, 8'hFF, 0, 0);
    check("pre_arst_vld",  32'(bus.out_valid), 32'd1);
    check("pre_arst_pend", 32'(bus.pending),   32'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld",  32'(bus.out_valid), 32'd0);
    check("arst_pend", 32'(bus.pending),   32'd0);
    check("arst_idx",  32'(bus.out_idx),   32'd0);
    model_reset();
    bus.req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(8'h01, 8'hFF, 0, 1);
    cyc(8'h00, 8'hFF, 0, 1);
    check("post_arst_idx", 32'(bus.out_idx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_pending_arb.md
Name: irq_pending_arb

Overview:
- Sequential front-end for the 8-to-3 priority encoder stage. It captures request events on 8 lines into a pending register and applies an enable mask.
- It presents the highest-index pending, enabled request as a registered 3-bit index with a valid/ready handshake.
- It clears each pending bit when the consumer accepts it.
- Sits between raw request sources (interrupts, channel requests) and the index consumer.

Parameters:
- N, 8, number of request lines; index width IDX_W = clog2(N), 3 at default.
- EDGE, 1, capture mode: 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N  request lines, synchronous to clk.
- en_mask  in  N  per-line enable; 1 = eligible for presentation.
- clr_all  in  1  synchronous clear of all pending bits.
- out_valid  out  1  out_idx holds an accepted-able request.
- out_idx  out  IDX_W  index of the presented request, highest index wins.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a clk edge.
- pending  out  N  current pending register, for status readback.

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, req_d=0, out_valid=0, out_idx=0. All held until the first clk edge after rst_n rises.
- Capture:
  - EDGE=1: set_vec = req & ~req_d, with req_d a 1-cycle delayed copy of req.
  - EDGE=0: set_vec = req.
- Clear:
  - clr_vec = one-hot(out_idx) when out_valid && out_ready, else 0.
  - clr_all forces clr_vec to all-ones.
- Pending update each edge: pending <= (pending & ~clr_vec) | set_vec.
  - Set wins over a handshake clear on the same bit, so a new event is never lost.
  - Set also wins over clr_all.
- Masked lines still latch pending but are not presented. Enabling a masked line later presents it.
- Candidate: cand = pending & ~clr_vec & en_mask. Note: this is the current pending, not the set_vec of this cycle.
  - cand_idx = highest set bit of cand.
  - cand_any = |cand.
- Output register loads when !out_valid or (out_valid && out_ready):
  - out_valid <= cand_any.
  - out_idx <= cand_idx if cand_any, else out_idx holds.
- While out_valid && !out_ready, out_valid and out_idx hold stable. This holds even if en_mask drops that line or a higher request arrives; there is no retraction.
- clr_all while out_valid && !out_ready: pending clears, but the presented out_idx stays valid until accepted. Its clear on acceptance is a no-op.
- Latency:
  - EDGE=1: req rises before edge k, pending set at edge k, out_valid at edge k+1. That is 2 edges when the output is idle.
  - Back-to-back: after acceptance at edge k, the next candidate is presented at the same edge k (out_valid stays 1), giving 1 index per cycle throughput.
- Empty: cand_any=0 gives out_valid=0, and out_idx keeps its last value (don't-care).
- Level mode: if req stays high after acceptance, the bit re-sets on the same edge and is presented again.

Decomposition:
- Shared package: N_REQ=8, IDX_W=3, and a function onehot(idx) returning N bits.
- One natural sub-module: irq_prio_enc, a combinational N-to-IDX_W highest-index-first encoder with an any output. It is instantiated once for cand.

Test Plan:
- Reset/basic:
  - Stimulus: reset, then EDGE=1, en_mask=8'hFF, req=8'h20 pulsed 1 cycle, out_ready=1.
  - Required: pending=8'h20 after edge 1; out_valid=1, out_idx=5 after edge 2; pending=0 and out_valid=0 after edge 3.
- Priority plus back-to-back:
  - Stimulus: req pulses 8'h8A simultaneously, out_ready=1.
  - Required: out_idx sequence 7, 3, 1 on consecutive cycles, then out_valid=0; pending ends at 0.
- Hold under backpressure:
  - Stimulus: pending 8'h04 presented (idx 2), out_ready=0, then req 8'h80 pulses and en_mask bit2 drops.
  - Required: out_idx stays 2 with out_valid=1.
  - Then out_ready=1: accept 2, next cycle out_idx=7.
- Mask:
  - Stimulus: en_mask=8'h0F, req pulse 8'hF0.
  - Required: pending=8'hF0, out_valid stays 0.
  - Then set en_mask=8'hFF: out_idx=7 next edge.
- Set beats clear:
  - Stimulus: idx 4 accepted on the same edge as a new rising req[4].
  - Required: pending[4]=1 after the edge; idx 4 presented again.
- Async reset mid-operation:
  - Stimulus: drop rst_n between edges while out_valid=1, pending=8'h33.
  - Required: out_valid=0 and pending=0 immediately, without waiting for a clk edge.
